// File: rtl/pie_pkg.sv
// Shared definitions for the PIE decoder: FSM state encoding and the default
// symbol timings (in samples) that match pie_encoder.
package pie_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DELIM,
    WAIT_HI,
    DATA0,
    RTCAL,
    CAL,
    DATA
  } pie_state_t;

  localparam int PIE_PW    = 2;
  localparam int PIE_ZERO  = 6;
  localparam int PIE_ONE   = 10;
  localparam int PIE_RTCAL = 16;
  localparam int PIE_TRCAL = 32;
  localparam int PIE_DELIM = 3;

endpackage

// File: rtl/pie_edge_meter.sv
// Line edge detector and saturating run-length counters for the PIE decoder.
// rise/fall are qualified by in_vld. On a rising sample sym_len is the length
// of the symbol just completed (previous rise up to this one); low_len is the
// low run including the current sample, or the run that just ended on a rise;
// high_len is the high run including the current sample.
module pie_edge_meter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_dat,
  input  logic                 in_vld,
  output logic                 rise,
  output logic                 fall,
  output logic [CNT_WIDTH-1:0] sym_len,
  output logic [CNT_WIDTH-1:0] low_len,
  output logic [CNT_WIDTH-1:0] high_len
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 prev;
  logic [CNT_WIDTH-1:0] sym_cnt;
  logic [CNT_WIDTH-1:0] low_cnt;
  logic [CNT_WIDTH-1:0] high_cnt;
  logic [CNT_WIDTH-1:0] sym_inc;
  logic [CNT_WIDTH-1:0] low_inc;
  logic [CNT_WIDTH-1:0] high_inc;

  assign rise = in_vld & ~prev & in_dat;
  assign fall = in_vld & prev & ~in_dat;

  // Counters stick at all-ones instead of wrapping
  assign sym_inc  = (sym_cnt  == CNT_MAX) ? sym_cnt  : sym_cnt  + CNT_ONE;
  assign low_inc  = (low_cnt  == CNT_MAX) ? low_cnt  : low_cnt  + CNT_ONE;
  assign high_inc = (high_cnt == CNT_MAX) ? high_cnt : high_cnt + CNT_ONE;

  assign sym_len  = rise ? sym_cnt : sym_inc;
  assign low_len  = in_dat ? low_cnt : low_inc;
  assign high_len = in_dat ? high_inc : '0;

  // Track last valid sample and run lengths; the rising sample opens a new symbol
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev     <= 1'b1;
      sym_cnt  <= '0;
      low_cnt  <= '0;
      high_cnt <= '0;
    end else if (in_vld) begin
      prev     <= in_dat;
      sym_cnt  <= rise ? CNT_ONE : sym_inc;
      low_cnt  <= in_dat ? '0 : low_inc;
      high_cnt <= in_dat ? high_inc : '0;
    end
  end

endmodule

// File: rtl/pie_decoder.sv
// PIE tag-side decoder: finds delimiter, data-0 (tari), RTcal and optional
// TRcal, then slices each data symbol against pivot = RTcal/2. All strobes are
// registered one clock after the qualifying in_vld sample.
module pie_decoder
  import pie_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int DELIM_MIN = 2,
  parameter int DELIM_MAX = 5,
  parameter int PW_MAX    = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_dat,
  input  logic                 in_vld,
  output logic                 out_dat,
  output logic                 out_vld,
  output logic                 frame_start,
  output logic                 trcal_seen,
  output logic [CNT_WIDTH-1:0] rtcal_len,
  output logic [CNT_WIDTH-1:0] trcal_len,
  output logic                 frame_end,
  output logic                 err
);

  localparam logic [CNT_WIDTH-1:0] DMIN = CNT_WIDTH'(DELIM_MIN);
  localparam logic [CNT_WIDTH-1:0] DMAX = CNT_WIDTH'(DELIM_MAX);
  localparam logic [CNT_WIDTH-1:0] PWM  = CNT_WIDTH'(PW_MAX);
  localparam logic [CNT_WIDTH-1:0] TMO  = CNT_WIDTH'(TIMEOUT);

  pie_state_t state;
  pie_state_t state_next;

  logic                 rise;
  logic                 fall;
  logic [CNT_WIDTH-1:0] sym_len;
  logic [CNT_WIDTH-1:0] low_len;
  logic [CNT_WIDTH-1:0] high_len;
  logic [CNT_WIDTH-1:0] tari;
  logic [CNT_WIDTH-1:0] pivot;

  logic restart;
  logic timeout;
  logic delim_ok;
  logic delim_long;
  logic rt_ok;
  logic over_rt;

  logic bit_stb;
  logic trcal_stb;
  logic start_stb;
  logic err_stb;
  logic end_stb;
  logic tari_ld;

  pie_edge_meter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_meter (
    .clk     (clk),
    .rst     (rst),
    .in_dat  (in_dat),
    .in_vld  (in_vld),
    .rise    (rise),
    .fall    (fall),
    .sym_len (sym_len),
    .low_len (low_len),
    .high_len(high_len)
  );

  // An over-long low pulse inside a frame is treated as a new delimiter
  assign restart    = in_vld & ~in_dat & (low_len > PWM);
  assign timeout    = in_vld & in_dat & (high_len >= TMO);
  assign delim_ok   = (low_len >= DMIN) && (low_len <= DMAX);
  assign delim_long = in_vld & ~in_dat & (low_len > DMAX);
  assign rt_ok      = sym_len > tari;
  assign over_rt    = sym_len > rtcal_len;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic; restart, rise and timeout are mutually exclusive per sample
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (fall) state_next = DELIM;
      DELIM: begin
        if (rise)            state_next = delim_ok ? DATA0 : IDLE;
        else if (delim_long) state_next = WAIT_HI;
      end
      WAIT_HI: if (rise) state_next = IDLE;
      DATA0: begin
        if (restart)      state_next = DELIM;
        else if (rise)    state_next = RTCAL;
        else if (timeout) state_next = IDLE;
      end
      RTCAL: begin
        if (restart)      state_next = DELIM;
        else if (rise)    state_next = rt_ok ? CAL : IDLE;
        else if (timeout) state_next = IDLE;
      end
      CAL: begin
        if (restart)      state_next = DELIM;
        else if (rise)    state_next = DATA;
        else if (timeout) state_next = IDLE;
      end
      DATA: begin
        if (restart)      state_next = DELIM;
        else if (rise)    state_next = over_rt ? IDLE : DATA;
        else if (timeout) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-sample actions: which strobe fires and which measurement is latched
  always_comb begin
    bit_stb   = 1'b0;
    trcal_stb = 1'b0;
    start_stb = 1'b0;
    err_stb   = 1'b0;
    end_stb   = 1'b0;
    tari_ld   = 1'b0;
    unique case (state)
      DELIM: begin
        if (rise)            err_stb = ~delim_ok;
        else if (delim_long) err_stb = 1'b1;
      end
      DATA0: begin
        if (rise)         tari_ld = 1'b1;
        else if (timeout) err_stb = 1'b1;
      end
      RTCAL: begin
        if (rise) begin
          start_stb = rt_ok;
          err_stb   = ~rt_ok;
        end else if (timeout) begin
          err_stb = 1'b1;
        end
      end
      CAL: begin
        if (rise) begin
          trcal_stb = over_rt;
          bit_stb   = ~over_rt;
        end else if (timeout) begin
          end_stb = 1'b1;
        end
      end
      DATA: begin
        if (rise) begin
          err_stb = over_rt;
          bit_stb = ~over_rt;
        end else if (timeout) begin
          end_stb = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and frame calibration; rtcal/trcal hold until the next frame_start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_dat     <= 1'b0;
      out_vld     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      err         <= 1'b0;
      trcal_seen  <= 1'b0;
      rtcal_len   <= '0;
      trcal_len   <= '0;
      tari        <= '0;
      pivot       <= '0;
    end else begin
      out_vld     <= bit_stb;
      frame_start <= start_stb;
      frame_end   <= end_stb;
      err         <= err_stb;
      if (bit_stb) out_dat <= (sym_len >= pivot);
      if (tari_ld) tari <= sym_len;
      if (start_stb) begin
        rtcal_len  <= sym_len;
        pivot      <= sym_len >> 1;
        trcal_len  <= '0;
        trcal_seen <= 1'b0;
      end
      if (trcal_stb) begin
        trcal_len  <= sym_len;
        trcal_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pie_decoder.sv
// Scoreboard bench for pie_decoder: stimulus pushes expected strobes into a
// queue, a negedge monitor pops and compares each strobe the DUT emits.
module tb_pie_decoder;
  import pie_pkg::*;

  localparam int K_BIT   = 0;
  localparam int K_START = 1;
  localparam int K_ERR   = 2;
  localparam int K_END   = 3;

  typedef struct {
    int kind;
    int v0;
    int v1;
    int v2;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_dat = 1'b1;
  logic       in_vld = 1'b0;
  logic       out_dat;
  logic       out_vld;
  logic       frame_start;
  logic       trcal_seen;
  logic [7:0] rtcal_len;
  logic [7:0] trcal_len;
  logic       frame_end;
  logic       err;

  ev_t exp_q[$];
  int  compared   = 0;
  int  mismatched = 0;
  bit  toggle_vld = 1'b0;

  always #5 clk = ~clk;

  pie_decoder #(
    .CNT_WIDTH(8),
    .DELIM_MIN(2),
    .DELIM_MAX(5),
    .PW_MAX   (4),
    .TIMEOUT  (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_dat     (in_dat),
    .in_vld     (in_vld),
    .out_dat    (out_dat),
    .out_vld    (out_vld),
    .frame_start(frame_start),
    .trcal_seen (trcal_seen),
    .rtcal_len  (rtcal_len),
    .trcal_len  (trcal_len),
    .frame_end  (frame_end),
    .err        (err)
  );

  task automatic expect_ev(input int k, input int a, input int b, input int c);
    exp_q.push_back(ev_t'{k, a, b, c});
  endtask

  task automatic pop_check(input string name, input int k, input int a, input int b, input int c);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL %s: unexpected strobe got v=%0d/%0d/%0d, required none", name, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.v0 != a || e.v1 != b || e.v2 != c)
        begin
          mismatched++;
          $display("FAIL %s: got kind=%0d v=%0d/%0d/%0d, required kind=%0d v=%0d/%0d/%0d",
                   name, k, a, b, c, e.kind, e.v0, e.v1, e.v2);
        end else begin
          $display("ok   %s: v=%0d/%0d/%0d", name, a, b, c);
        end
    end
  endtask

  // Monitor: compare every strobe against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (frame_start) pop_check("frame_start", K_START, int'(rtcal_len), int'(trcal_seen), int'(trcal_len));
      if (out_vld)     pop_check("bit", K_BIT, int'(out_dat), 0, 0);
      if (err)         pop_check("err", K_ERR, 0, 0, 0);
      if (frame_end)   pop_check("frame_end", K_END, int'(rtcal_len), int'(trcal_seen), int'(trcal_len));
    end
  end

  task automatic send(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_dat = v;
      in_vld = 1'b1;
      if (toggle_vld) begin
        @(posedge clk); #1;
        in_dat = ~v;
        in_vld = 1'b0;
      end
    end
  endtask

  // One PIE symbol measured rise-to-rise: high part then a PW low pulse
  task automatic sym(input int len);
    send(1'b1, len - PIE_PW);
    send(1'b0, PIE_PW);
  endtask

  task automatic frame_head(input int rt, input int tr);
    send(1'b1, 4);
    send(1'b0, PIE_DELIM);
    sym(PIE_ZERO);
    sym(rt);
    if (tr > 0) sym(tr);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_%s: %0d events pending, required 0", tag, exp_q.size());
      exp_q.delete();
    end else begin
      $display("ok   drain_%s: scoreboard empty", tag);
    end
  endtask

  task automatic check_zero(input string tag);
    logic [20:0] v;
    v = {out_vld, out_dat, frame_start, frame_end, err, trcal_seen, rtcal_len, trcal_len};
    compared++;
    if (v != '0) begin
      mismatched++;
      $display("FAIL %s: outputs=%h, required 0", tag, v);
    end else begin
      $display("ok   %s: outputs all zero", tag);
    end
  endtask

  // Frame with bits 1,0,1 and optional TRcal, ended by a high-level timeout
  task automatic frame_101(input int tr);
    expect_ev(K_START, PIE_RTCAL, 0, 0);
    expect_ev(K_BIT, 1, 0, 0);
    expect_ev(K_BIT, 0, 0, 0);
    expect_ev(K_BIT, 1, 0, 0);
    expect_ev(K_END, PIE_RTCAL, (tr > 0) ? 1 : 0, tr);
    frame_head(PIE_RTCAL, tr);
    sym(PIE_ONE);
    sym(PIE_ZERO);
    sym(PIE_ONE);
    send(1'b1, 70);
  endtask

  // Pivot boundary: 7 < 8 -> 0, 8 == 8 -> 1, 9 -> 1
  task automatic frame_boundary();
    expect_ev(K_START, PIE_RTCAL, 0, 0);
    expect_ev(K_BIT, 0, 0, 0);
    expect_ev(K_BIT, 1, 0, 0);
    expect_ev(K_BIT, 1, 0, 0);
    expect_ev(K_END, PIE_RTCAL, 0, 0);
    frame_head(PIE_RTCAL, 0);
    sym(7);
    sym(8);
    sym(9);
    send(1'b1, 70);
  endtask

  initial begin
    #12;
    check_zero("reset_state");
    rst = 1'b1;

    frame_101(0);
    drain("no_trcal");

    frame_101(PIE_TRCAL);
    drain("trcal");

    frame_boundary();
    drain("boundary");

    // Over-long delimiter: err on the 6th low sample, then a clean frame
    expect_ev(K_ERR, 0, 0, 0);
    send(1'b1, 4);
    send(1'b0, 7);
    send(1'b1, 5);
    frame_101(0);
    drain("long_delim");

    // Mid-frame low pulse longer than PW_MAX restarts the frame
    expect_ev(K_START, PIE_RTCAL, 0, 0);
    expect_ev(K_BIT, 1, 0, 0);
    expect_ev(K_BIT, 0, 0, 0);
    expect_ev(K_START, 14, 0, 0);
    expect_ev(K_BIT, 1, 0, 0);
    expect_ev(K_END, 14, 0, 0);
    frame_head(PIE_RTCAL, PIE_TRCAL);
    sym(PIE_ONE);
    sym(PIE_ZERO);
    send(1'b1, 3);
    send(1'b0, 5);
    sym(PIE_ZERO);
    sym(14);
    sym(PIE_ONE);
    send(1'b1, 70);
    drain("restart");

    // Same frame with in_vld gaps between samples
    toggle_vld = 1'b1;
    frame_101(0);
    drain("vld_gaps");
    toggle_vld = 1'b0;

    // Async reset right after an out_vld is registered mid-DATA
    expect_ev(K_START, PIE_RTCAL, 0, 0);
    expect_ev(K_BIT, 1, 0, 0);
    frame_head(PIE_RTCAL, 0);
    sym(PIE_ONE);
    send(1'b1, PIE_ZERO - PIE_PW);
    send(1'b0, PIE_PW);
    @(posedge clk); #1;
    in_dat = 1'b1;
    in_vld = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (!(out_vld == 1'b1 && out_dat == 1'b0 && rtcal_len == 8'd16)) begin
      mismatched++;
      $display("FAIL pre_rst_bit: vld=%0d dat=%0d rtcal=%0d, required 1/0/16", out_vld, out_dat, rtcal_len);
    end else begin
      $display("ok   pre_rst_bit: vld=1 dat=0 rtcal=16");
    end
    in_vld = 1'b0;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    drain("pre_reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;

    frame_boundary();
    drain("after_reset");

    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
